sad_search_ctrl: RTL and testbench

- Sequences a full-search block-matching pass over a square offset window.
- For each (dx, dy) offset, requests one 16x16 difference window from the pixel buffer, waits for the registered 256-input tree-sum, and tracks the minimum sum and its offset.
- Sits between the frame-alignment top level and the window-fetch/tree-sum datapath; one search per start pulse.

---
 rtl/sad_search_ctrl.sv | 148 ++++++++++++++
 tb/tb_sad_search_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl: full-search block-matching sequencer.
//
// Walks every (dx, dy) offset in [-RANGE, +RANGE]^2 in raster order (dx fastest).
// For each offset it issues one window fetch request, waits for the tree-sum of
// that window and keeps the strictly smallest sum together with its offset.
// Ties keep the earlier candidate.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start              one-cycle pulse; accepted only while idle
//   win_req/win_ack    window fetch handshake; win_dx/win_dy stable while win_req
//   sum_valid/sum_in   tree-sum strobe and value for the last acked window
//   busy, done         search in progress / one-cycle result-valid pulse
//   best_dx/dy/sum     offset and value of the minimum sum (held until next start)
//
// Optional build macro SAD_EARLY_EXIT_EN adds input thresh and output
// early_exit. Once the running minimum is <= thresh the search ends at once
// and early_exit is raised with done.
module sad_search_ctrl #(
  parameter int INPUT_SIZE = 9,
  parameter int RANGE      = 4,
  parameter int OFF_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         win_req,
  output logic signed [OFF_W-1:0]      win_dx,
  output logic signed [OFF_W-1:0]      win_dy,
  input  logic                         win_ack,
  input  logic                         sum_valid,
  input  logic signed [INPUT_SIZE+7:0] sum_in,
`ifdef SAD_EARLY_EXIT_EN
  input  logic signed [INPUT_SIZE+7:0] thresh,
  output logic                         early_exit,
`endif
  output logic                         busy,
  output logic                         done,
  output logic signed [OFF_W-1:0]      best_dx,
  output logic signed [OFF_W-1:0]      best_dy,
  output logic signed [INPUT_SIZE+7:0] best_sum
);

  localparam int SW = INPUT_SIZE + 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_CMP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic signed [OFF_W-1:0] OFF_MAX = OFF_W'(RANGE);
  localparam logic signed [OFF_W-1:0] OFF_MIN = -OFF_MAX;
  localparam logic signed [SW-1:0]    SUM_MAX = {1'b0, {(SW-1){1'b1}}};

  logic [2:0]              state_q, state_d;
  logic signed [OFF_W-1:0] dx_q, dy_q;
  logic signed [SW-1:0]    sum_q;      // sum captured on the sum_valid strobe
  logic                    better;
  logic                    last;
  logic                    early_hit;

  assign better = sum_q < best_sum;
  assign last   = (dx_q == OFF_MAX) && (dy_q == OFF_MAX);

`ifdef SAD_EARLY_EXIT_EN
  logic signed [SW-1:0] upd_best;
  logic                 early_q;

  assign upd_best   = better ? sum_q : best_sum;
  assign early_hit  = upd_best <= thresh;
  assign early_exit = early_q;
`else
  assign early_hit  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_REQ;
      ST_REQ:  if (win_ack) state_d = ST_WAIT;
      ST_WAIT: if (sum_valid) state_d = ST_CMP;
      ST_CMP:  state_d = (last || early_hit) ? ST_DONE : ST_REQ;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dx_q     <= '0;
      dy_q     <= '0;
      sum_q    <= '0;
      best_sum <= '0;
      best_dx  <= '0;
      best_dy  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dx_q     <= OFF_MIN;
            dy_q     <= OFF_MIN;
            best_sum <= SUM_MAX;
            best_dx  <= OFF_MIN;
            best_dy  <= OFF_MIN;
          end
        end
        ST_WAIT: begin
          if (sum_valid) sum_q <= sum_in;
        end
        ST_CMP: begin
          if (better) begin
            best_sum <= sum_q;
            best_dx  <= dx_q;
            best_dy  <= dy_q;
          end
          // Advance only when another request follows; the final offset is held.
          if (state_d == ST_REQ) begin
            if (dx_q == OFF_MAX) begin
              dx_q <= OFF_MIN;
              dy_q <= dy_q + OFF_W'(1);
            end else begin
              dx_q <= dx_q + OFF_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SAD_EARLY_EXIT_EN
  // Hitting the threshold on the final candidate is a normal finish, not early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) early_q <= 1'b0;
    else     early_q <= (state_q == ST_CMP) && early_hit && !last;
  end
`endif

  assign win_req = (state_q == ST_REQ);
  assign win_dx  = dx_q;
  assign win_dy  = dy_q;
  assign busy    = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_CMP);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl with RANGE=1 (3x3 candidates).
module tb_sad_search_ctrl;

  logic               clk;
  logic               rst;
  logic               start;
  logic               win_req;
  logic signed [7:0]  win_dx;
  logic signed [7:0]  win_dy;
  logic               win_ack;
  logic               sum_valid;
  logic signed [16:0] sum_in;
  logic               busy;
  logic               done;
  logic signed [7:0]  best_dx;
  logic signed [7:0]  best_dy;
  logic signed [16:0] best_sum;
`ifdef SAD_EARLY_EXIT_EN
  logic signed [16:0] thresh;
  logic               early_exit;
`endif

  int checks;
  int failures;

  int sums [9];
  int ncyc;
  int nhs;
  int raster_err;
  int stable_err;
  int busy_err;
  bit got_done;

  sad_search_ctrl #(
    .INPUT_SIZE (9),
    .RANGE      (1),
    .OFF_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .win_req    (win_req),
    .win_dx     (win_dx),
    .win_dy     (win_dy),
    .win_ack    (win_ack),
    .sum_valid  (sum_valid),
    .sum_in     (sum_in),
`ifdef SAD_EARLY_EXIT_EN
    .thresh     (thresh),
    .early_exit (early_exit),
`endif
    .busy       (busy),
    .done       (done),
    .best_dx    (best_dx),
    .best_dy    (best_dy),
    .best_sum   (best_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one search and acts as the window/tree-sum responder. Returns at the
  // done pulse (inputs are sampled on the falling edge), after abort_hs
  // handshakes when abort_hs > 0, or when the cycle budget runs out.
  task automatic run_search(input int ack_dly, input int sv_dly, input bit mid_start,
                            input int abort_hs);
    int rq;
    int pend;
    int idx;
    logic signed [7:0] hdx;
    logic signed [7:0] hdy;
    ncyc = 0; nhs = 0; raster_err = 0; stable_err = 0; busy_err = 0; got_done = 0;
    rq = 0; pend = -1; idx = 0; hdx = '0; hdy = '0;
    @(negedge clk);
    start = 1'b1;
    ncyc  = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ncyc++;
      start     = mid_start && (ncyc == 7);
      win_ack   = 1'b0;
      sum_valid = 1'b0;
      if (done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      if (abort_hs > 0 && nhs >= abort_hs) break;
      if (busy !== 1'b1) busy_err++;
      if (pend >= 0) begin
        pend++;
        if (pend == sv_dly) begin
          sum_valid = 1'b1;
          sum_in    = 17'(sums[idx-1]);
          pend      = -1;
        end
      end
      if (win_req === 1'b1) begin
        if (rq == 0) begin
          hdx = win_dx;
          hdy = win_dy;
          if (win_dx !== 8'(idx % 3 - 1) || win_dy !== 8'(idx / 3 - 1)) raster_err++;
        end else if (win_dx !== hdx || win_dy !== hdy) begin
          stable_err++;
        end
        if (rq == ack_dly) begin
          win_ack = 1'b1;
          idx++;
          nhs++;
          pend = 0;
          rq   = 0;
        end else begin
          rq++;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    if (win_req !== 1'b0) begin $display("FAIL reset_win_req got %b want 0", win_req); failures++; end
    checks++;
    if (win_dx !== 8'sd0) begin $display("FAIL reset_win_dx got %0d want 0", win_dx); failures++; end
    checks++;
    if (win_dy !== 8'sd0) begin $display("FAIL reset_win_dy got %0d want 0", win_dy); failures++; end
    checks++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); failures++; end
    checks++;
    if (done !== 1'b0) begin $display("FAIL reset_done got %b want 0", done); failures++; end
    checks++;
    if (best_sum !== 17'sd0) begin $display("FAIL reset_best_sum got %0d want 0", best_sum); failures++; end
    checks++;
    if (best_dx !== 8'sd0 || best_dy !== 8'sd0) begin
      $display("FAIL reset_best_off got (%0d,%0d) want (0,0)", best_dx, best_dy); failures++;
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int after_err;
    sums = '{90, 80, 70, 60, 10, 60, 70, 80, 90};
    run_search(0, 1, 1'b0, 0);
    if (got_done !== 1'b1) begin $display("FAIL basic_done got %b want 1", got_done); failures++; end
    checks++;
    if (ncyc != 29) begin $display("FAIL basic_cycles got %0d want 29", ncyc); failures++; end
    checks++;
    if (nhs != 9) begin $display("FAIL basic_handshakes got %0d want 9", nhs); failures++; end
    checks++;
    if (raster_err != 0) begin $display("FAIL basic_raster got %0d want 0", raster_err); failures++; end
    checks++;
    if (busy_err != 0) begin $display("FAIL basic_busy got %0d want 0", busy_err); failures++; end
    checks++;
    if (busy !== 1'b0) begin $display("FAIL basic_busy_in_done got %b want 0", busy); failures++; end
    checks++;
    if (best_dx !== 8'sd0 || best_dy !== 8'sd0) begin
      $display("FAIL basic_best_off got (%0d,%0d) want (0,0)", best_dx, best_dy); failures++;
    end
    checks++;
    if (best_sum !== 17'sd10) begin $display("FAIL basic_best_sum got %0d want 10", best_sum); failures++; end
    checks++;
`ifdef SAD_EARLY_EXIT_EN
    if (early_exit !== 1'b0) begin $display("FAIL basic_early_exit got %b want 0", early_exit); failures++; end
    checks++;
`endif
    // start coinciding with the done pulse is ignored; nothing more is requested
    start = 1'b1;
    after_err = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (win_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) after_err++;
    end
    if (after_err != 0) begin $display("FAIL start_in_done got %0d want 0", after_err); failures++; end
    checks++;
    if (best_sum !== 17'sd10) begin $display("FAIL basic_hold_sum got %0d want 10", best_sum); failures++; end
    checks++;
  endtask

  task automatic test_tie;
    sums = '{50, 50, 50, 50, 50, 50, 50, 50, 50};
    run_search(0, 1, 1'b0, 0);
    if (got_done !== 1'b1) begin $display("FAIL tie_done got %b want 1", got_done); failures++; end
    checks++;
    if (best_dx !== -8'sd1 || best_dy !== -8'sd1) begin
      $display("FAIL tie_best_off got (%0d,%0d) want (-1,-1)", best_dx, best_dy); failures++;
    end
    checks++;
    if (best_sum !== 17'sd50) begin $display("FAIL tie_best_sum got %0d want 50", best_sum); failures++; end
    checks++;
  endtask

  task automatic test_back_pressure;
    sums = '{90, 80, 70, 60, 10, 60, 70, 80, 90};
    run_search(3, 5, 1'b0, 0);
    if (got_done !== 1'b1) begin $display("FAIL bp_done got %b want 1", got_done); failures++; end
    checks++;
    if (ncyc != 92) begin $display("FAIL bp_cycles got %0d want 92", ncyc); failures++; end
    checks++;
    if (stable_err != 0) begin $display("FAIL bp_offset_stable got %0d want 0", stable_err); failures++; end
    checks++;
    if (raster_err != 0 || nhs != 9) begin
      $display("FAIL bp_raster got err=%0d hs=%0d want err=0 hs=9", raster_err, nhs); failures++;
    end
    checks++;
    if (best_dx !== 8'sd0 || best_dy !== 8'sd0 || best_sum !== 17'sd10) begin
      $display("FAIL bp_best got (%0d,%0d) %0d want (0,0) 10", best_dx, best_dy, best_sum);
      failures++;
    end
    checks++;
  endtask

  task automatic test_negative;
    sums = '{0, 0, 0, 0, 0, 0, 0, -200, 0};
    run_search(0, 1, 1'b0, 0);
    if (got_done !== 1'b1) begin $display("FAIL neg_done got %b want 1", got_done); failures++; end
    checks++;
    if (best_dx !== 8'sd0 || best_dy !== 8'sd1) begin
      $display("FAIL neg_best_off got (%0d,%0d) want (0,1)", best_dx, best_dy); failures++;
    end
    checks++;
    if (best_sum !== -17'sd200) begin $display("FAIL neg_best_sum got %0d want -200", best_sum); failures++; end
    checks++;
  endtask

  task automatic test_abort;
    sums = '{90, 80, 70, 60, 10, 60, 70, 80, 90};
    run_search(0, 1, 1'b1, 4);
    if (raster_err != 0 || busy_err != 0) begin
      $display("FAIL abort_mid_start got raster=%0d busy=%0d want 0 0", raster_err, busy_err);
      failures++;
    end
    checks++;
    #2 rst = 1'b1;
    #1;
    if (win_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || win_dx !== 8'sd0 || win_dy !== 8'sd0) begin
      $display("FAIL abort_ctrl got req=%b busy=%b done=%b dx=%0d dy=%0d want all 0",
               win_req, busy, done, win_dx, win_dy);
      failures++;
    end
    checks++;
    if (best_sum !== 17'sd0 || best_dx !== 8'sd0 || best_dy !== 8'sd0) begin
      $display("FAIL abort_best got (%0d,%0d) %0d want (0,0) 0", best_dx, best_dy, best_sum);
      failures++;
    end
    checks++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_search(0, 1, 1'b0, 0);
    if (got_done !== 1'b1 || ncyc != 29) begin
      $display("FAIL abort_restart got done=%b cycles=%0d want 1 29", got_done, ncyc); failures++;
    end
    checks++;
    if (best_dx !== 8'sd0 || best_dy !== 8'sd0 || best_sum !== 17'sd10) begin
      $display("FAIL abort_restart_best got (%0d,%0d) %0d want (0,0) 10", best_dx, best_dy, best_sum);
      failures++;
    end
    checks++;
  endtask

`ifdef SAD_EARLY_EXIT_EN
  task automatic test_early_exit;
    sums   = '{90, 80, 70, 60, 10, 60, 70, 80, 90};
    thresh = 17'sd15;
    run_search(0, 1, 1'b0, 0);
    if (got_done !== 1'b1 || nhs != 5 || ncyc != 17) begin
      $display("FAIL early_count got done=%b hs=%0d cycles=%0d want 1 5 17", got_done, nhs, ncyc);
      failures++;
    end
    checks++;
    if (early_exit !== 1'b1) begin $display("FAIL early_flag got %b want 1", early_exit); failures++; end
    checks++;
    if (best_dx !== 8'sd0 || best_dy !== 8'sd0 || best_sum !== 17'sd10) begin
      $display("FAIL early_best got (%0d,%0d) %0d want (0,0) 10", best_dx, best_dy, best_sum);
      failures++;
    end
    checks++;
    @(negedge clk);
    if (early_exit !== 1'b0) begin $display("FAIL early_flag_clear got %b want 0", early_exit); failures++; end
    checks++;
    thresh = 17'sh10000;
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    win_ack   = 1'b0;
    sum_valid = 1'b0;
    sum_in    = '0;
`ifdef SAD_EARLY_EXIT_EN
    thresh    = 17'sh10000;
`endif
    test_reset();
    test_basic();
    test_tie();
    test_back_pressure();
    test_negative();
    test_abort();
`ifdef SAD_EARLY_EXIT_EN
    test_early_exit();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
